// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one fetch outstanding,
// and feeds the IF/ID pipeline register with {instr, pc, pc+4}.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall_id,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;

    logic [31:0] target_pc;
    logic [31:0] pc_plus4;
    logic        accept;
    logic        load;
    logic [31:0] load_instr;

    assign target_pc = redirect_pc & ~32'h3;
    assign pc_plus4  = pc_q + 32'd4;
    assign accept    = !if_id_valid_q || !stall_id;

    // Fetch control: the only state that may issue a request is S_REQ.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        load       = 1'b0;
        load_instr = hold_q;
        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_d = target_pc;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = target_pc;
                    state_d = imem_valid ? S_REQ : S_DRAIN;
                end else if (imem_valid) begin
                    if (accept) begin
                        load       = 1'b1;
                        load_instr = imem_rdata;
                        pc_d       = pc_plus4;
                        state_d    = S_REQ;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_DRAIN: begin
                // The stale response still has to arrive before refetching.
                if (redirect) begin
                    pc_d = target_pc;
                end
                if (imem_valid) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    hold_d  = 32'h0;
                    pc_d    = target_pc;
                    state_d = S_REQ;
                end else if (accept) begin
                    load       = 1'b1;
                    load_instr = hold_q;
                    pc_d       = pc_plus4;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // IF/ID register: flush beats stall, stall beats load, else bubble.
    always_comb begin
        if_id_valid_d = if_id_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if (redirect) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (stall_id && if_id_valid_q) begin
            if_id_valid_d = 1'b1;
        end else if (load) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = load_instr;
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_plus4;
        end else begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            hold_q        <= 32'h0;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= 32'h0;
            if_id_pc4_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_q        <= hold_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
        end
    end

    assign imem_req    = (state_q == S_REQ) && !redirect;
    assign imem_addr   = pc_q;
    assign if_id_valid = if_id_valid_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_pc4   = if_id_pc4_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a variable-latency memory plus a program-order model
// (next expected PC, restarted on redirect) checks every IF/ID entry.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        stall_id;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .stall_id    (stall_id),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_fail;
    int          cyc;
    int          resp_cyc;
    int          mem_lat;
    int          n_entries;
    logic        pending;
    logic        live;
    logic [31:0] req_addr;
    logic [31:0] exp_pc;
    logic        obs_req;
    logic [31:0] obs_addr;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: memory responds, request/redirect bookkeeping, then the
    // post-edge IF/ID contents are checked against the program-order model.
    task automatic cycle();
        logic        was_rst, was_redirect, was_held;
        logic [31:0] old_instr, old_pc, old_pc4;
        if (!rst && pending && cyc == resp_cyc) begin
            imem_valid = 1'b1;
            imem_rdata = pat(req_addr);
            pending    = 1'b0;
        end else begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
        end
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        if (rst) begin
            pending = 1'b0;
            live    = 1'b0;
        end else begin
            if (obs_req) begin
                chk("req_allowed", 32'(pending | live | redirect), 32'h0);
                chk("req_align", 32'(obs_addr[1:0]), 32'h0);
                pending  = 1'b1;
                live     = 1'b1;
                req_addr = obs_addr;
                resp_cyc = cyc + mem_lat;
            end
            if (redirect) begin
                live   = 1'b0;
                exp_pc = redirect_pc & ~32'h3;
            end
        end
        was_rst      = rst;
        was_redirect = redirect;
        was_held     = if_id_valid && stall_id && !redirect;
        old_instr    = if_id_instr;
        old_pc       = if_id_pc;
        old_pc4      = if_id_pc4;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (was_rst) begin
            exp_pc = 32'h0;
            chk("rst_valid", 32'(if_id_valid), 32'h0);
            chk("rst_instr", if_id_instr, NOP);
            chk("rst_pc", if_id_pc, 32'h0);
            chk("rst_pc4", if_id_pc4, 32'h0);
            chk("rst_addr", imem_addr, 32'h0);
        end else if (was_redirect) begin
            chk("flush_valid", 32'(if_id_valid), 32'h0);
            chk("flush_instr", if_id_instr, NOP);
        end else if (was_held) begin
            chk("hold_valid", 32'(if_id_valid), 32'h1);
            chk("hold_instr", if_id_instr, old_instr);
            chk("hold_pc", if_id_pc, old_pc);
            chk("hold_pc4", if_id_pc4, old_pc4);
        end else if (if_id_valid) begin
            chk("entry_pc", if_id_pc, exp_pc);
            chk("entry_instr", if_id_instr, pat(exp_pc));
            chk("entry_pc4", if_id_pc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            live   = 1'b0;
            n_entries++;
        end else begin
            chk("bubble_instr", if_id_instr, NOP);
        end
    endtask

    task automatic run_until_valid(input string tag, input logic [31:0] first_pc);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!if_id_valid && n < 40);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'h1);
        chk({tag, "_pc"}, if_id_pc, first_pc);
    endtask

    initial begin
        int          exp_v[7];
        logic [31:0] seen_pc[$];
        n_vec       = 0;
        n_fail      = 0;
        cyc         = 0;
        resp_cyc    = 0;
        mem_lat     = 1;
        n_entries   = 0;
        pending     = 1'b0;
        live        = 1'b0;
        req_addr    = 32'h0;
        exp_pc      = 32'h0;
        rst         = 1'b1;
        stall_id    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_valid  = 1'b0;
        imem_rdata  = 32'h0;
        exp_v       = '{0, 0, 1, 0, 1, 0, 1};

        // Reset, then 1-cycle memory streaming 0, 4, 8
        cycle();
        cycle();
        rst = 1'b0;
        chk("p0_valid", 32'(if_id_valid), 32'(exp_v[0]));
        for (int i = 1; i < 7; i++) begin
            cycle();
            if (i == 1) chk("req_after_rst", 32'(obs_req), 32'h1);
            chk("valid_pattern", 32'(if_id_valid), 32'(exp_v[i]));
            if (if_id_valid) seen_pc.push_back(if_id_pc);
        end
        chk("stream_len", 32'(seen_pc.size()), 32'd3);
        for (int i = 0; i < seen_pc.size(); i++)
            chk("stream_pc", seen_pc[i], 32'(4 * i));

        // Stall while pc=8 sits in IF/ID and the pc=C response arrives
        stall_id = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_pc", if_id_pc, 32'h8);
            chk("stall_valid", 32'(if_id_valid), 32'h1);
            if (k >= 1) chk("stall_noreq", 32'(obs_req), 32'h0);
        end
        stall_id = 1'b0;
        cycle();
        chk("release_pc", if_id_pc, 32'hC);
        chk("release_instr", if_id_instr, pat(32'hC));
        cycle();
        chk("next_req", 32'(obs_req), 32'h1);
        chk("next_addr", obs_addr, 32'h10);

        // Redirect while in REQ to an unaligned target
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        cycle();
        chk("redir_noreq", 32'(obs_req), 32'h0);
        redirect = 1'b0;
        cycle();
        chk("redir_req", 32'(obs_req), 32'h1);
        chk("redir_addr", obs_addr, 32'h100);
        run_until_valid("redir_first", 32'h100);

        // Redirect while waiting on a 4-cycle response
        mem_lat = 4;
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        cycle();
        chk("drain_valid", 32'(if_id_valid), 32'h0);
        chk("drain_instr", if_id_instr, NOP);
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("drain_noreq", 32'(obs_req), 32'h0);
            chk("drain_bubble", 32'(if_id_valid), 32'h0);
        end
        mem_lat = 2;
        cycle();
        chk("drain_req", 32'(obs_req), 32'h1);
        chk("drain_addr", obs_addr, 32'h200);
        run_until_valid("drain_first", 32'h200);

        // Redirect together with a stall while a response is buffered
        mem_lat  = 1;
        stall_id = 1'b1;
        cycle();
        cycle();
        chk("buf_pc", if_id_pc, 32'h200);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        cycle();
        chk("stallflush_valid", 32'(if_id_valid), 32'h0);
        chk("stallflush_instr", if_id_instr, 32'h13);
        redirect = 1'b0;
        stall_id = 1'b0;
        cycle();
        chk("stallflush_req", 32'(obs_req), 32'h1);
        chk("stallflush_addr", obs_addr, 32'h300);
        run_until_valid("stallflush_first", 32'h300);

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        run_until_valid("wrap_first", 32'hFFFF_FFFC);
        chk("wrap_pc4", if_id_pc4, 32'h0);
        cycle();
        chk("wrap_req", 32'(obs_req), 32'h1);
        chk("wrap_addr", obs_addr, 32'h0);

        // Reset in the middle of a fetch
        mem_lat = 3;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("midrst_req", 32'(obs_req), 32'h1);
        chk("midrst_addr", obs_addr, 32'h0);

        // Random traffic against the program-order model
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            stall_id    = ($urandom_range(0, 9) < 3);
            redirect    = !rst && ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
            mem_lat     = $urandom_range(1, 4);
            cycle();
        end
        rst      = 1'b0;
        stall_id = 1'b0;
        redirect = 1'b0;
        chk("liveness", 32'(n_entries > 150), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
